// File: rtl/eth_tx_arb_pkg.sv
// Shared types and elaboration helpers for the Ethernet TX frame arbiter.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } arb_state_t;

    function automatic int unsigned cnt_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic bit num_inputs_ok(input int unsigned n);
        return (n >= 2) && (n <= 8);
    endfunction

endpackage

// File: rtl/eth_tx_frame_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester found after 'last', wrapping modulo N.
module rr_pick
    import eth_tx_arb_pkg::*;
#(
    parameter int unsigned C_NUM_INPUTS = 2
) (
    input  logic [C_NUM_INPUTS-1:0]         req,
    input  logic [$clog2(C_NUM_INPUTS)-1:0] last,
    output logic [C_NUM_INPUTS-1:0]         gnt,
    output logic [$clog2(C_NUM_INPUTS)-1:0] idx
);

    localparam int unsigned IW = $clog2(C_NUM_INPUTS);

    int unsigned cand;
    logic        found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= C_NUM_INPUTS; k++) begin
            cand = (32'(last) + k) % C_NUM_INPUTS;
            if (!found && req[cand[IW-1:0]]) begin
                found                = 1'b1;
                gnt[cand[IW-1:0]]    = 1'b1;
                idx                  = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one 8-bit MAC TX AXI-Stream port.
// Frames longer than C_MAX_FRAME_LEN are cut, flagged as errored, and their tail drained.
module eth_tx_frame_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int unsigned C_NUM_INPUTS    = 2,
    parameter int unsigned C_MAX_FRAME_LEN = 1522
) (
    input  logic                        gtx_clk,
    input  logic                        gtx_rst_n,
    input  logic [8*C_NUM_INPUTS-1:0]   s_axis_tdata,
    input  logic [C_NUM_INPUTS-1:0]     s_axis_tvalid,
    input  logic [C_NUM_INPUTS-1:0]     s_axis_tlast,
    input  logic [C_NUM_INPUTS-1:0]     s_axis_tuser,
    output logic [C_NUM_INPUTS-1:0]     s_axis_tready,
    output logic [7:0]                  m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    input  logic                        m_axis_tready,
    output logic [C_NUM_INPUTS-1:0]     grant,
    output logic                        truncated
);

    localparam int unsigned   IW       = $clog2(C_NUM_INPUTS);
    localparam int unsigned   CW       = cnt_width(C_MAX_FRAME_LEN);
    localparam logic [CW-1:0] MAX_CNT  = CW'(C_MAX_FRAME_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(C_MAX_FRAME_LEN - 1);

    if (!num_inputs_ok(C_NUM_INPUTS)) begin : g_bad_num_inputs
        $error("eth_tx_frame_arbiter: C_NUM_INPUTS must be 2..8");
    end

    arb_state_t               state;
    logic [1:0]               rst_sync;
    logic                     rst_n_int;
    logic [IW-1:0]            last_idx;
    logic [CW-1:0]            byte_cnt;
    logic [C_NUM_INPUTS-1:0]  pick_gnt;
    logic [IW-1:0]            pick_idx;
    logic [7:0]               in_data;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_user;
    logic                     stage_ready;
    logic                     accept;
    logic                     at_max;
    logic                     cut;

    // Reset asserts immediately but releases two edges later, so no flop sees a runt release.
    always_ff @(posedge gtx_clk or negedge gtx_rst_n) begin
        if (!gtx_rst_n) rst_sync <= '0;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    rr_pick #(.C_NUM_INPUTS(C_NUM_INPUTS)) u_rr_pick (
        .req  (s_axis_tvalid),
        .last (last_idx),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // last_idx doubles as the current owner's index while a frame is in progress.
    always_comb begin
        in_data  = s_axis_tdata[{last_idx, 3'b000} +: 8];
        in_valid = s_axis_tvalid[last_idx];
        in_last  = s_axis_tlast[last_idx];
        in_user  = s_axis_tuser[last_idx];
    end

    assign stage_ready = ~m_axis_tvalid | m_axis_tready;

    always_comb begin
        s_axis_tready = '0;
        case (state)
            ST_PASS: s_axis_tready = grant & {C_NUM_INPUTS{stage_ready}};
            ST_DROP: s_axis_tready = grant;
            default: s_axis_tready = '0;
        endcase
    end

    assign accept = in_valid & s_axis_tready[last_idx];
    assign at_max = (byte_cnt == LAST_CNT);
    assign cut    = (state == ST_PASS) & accept & at_max & ~in_last;

    always_ff @(posedge gtx_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state    <= ST_IDLE;
            grant    <= '0;
            last_idx <= IW'(C_NUM_INPUTS - 1);
        end else begin
            case (state)
                ST_IDLE: if (|s_axis_tvalid) begin
                    state    <= ST_PASS;
                    grant    <= pick_gnt;
                    last_idx <= pick_idx;
                end
                ST_PASS: if (accept) begin
                    if (in_last) begin
                        state <= ST_IDLE;
                        grant <= '0;
                    end else if (at_max) begin
                        state <= ST_DROP;
                    end
                end
                ST_DROP: if (accept && in_last) begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge gtx_clk or negedge rst_n_int) begin
        if (!rst_n_int)                              byte_cnt <= '0;
        else if (state == ST_IDLE)                   byte_cnt <= '0;
        else if (accept && (byte_cnt != MAX_CNT))    byte_cnt <= byte_cnt + CW'(1);
    end

    always_ff @(posedge gtx_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            truncated     <= 1'b0;
        end else begin
            truncated <= cut;
            if (stage_ready) begin
                m_axis_tvalid <= (state == ST_PASS) & accept;
                if ((state == ST_PASS) && accept) begin
                    m_axis_tdata <= in_data;
                    m_axis_tlast <= in_last | at_max;
                    m_axis_tuser <= in_user | (at_max & ~in_last);
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Randomized bench for eth_tx_frame_arbiter: per-source frame queues, a round-robin
// ordering model and an output scoreboard that applies the truncation rule to whole frames.
module tb_eth_tx_frame_arbiter;

    localparam int unsigned N    = 3;
    localparam int unsigned MAXL = 40;

    logic             gtx_clk = 1'b0;
    logic             gtx_rst_n;
    logic [8*N-1:0]   s_axis_tdata;
    logic [N-1:0]     s_axis_tvalid;
    logic [N-1:0]     s_axis_tlast;
    logic [N-1:0]     s_axis_tuser;
    logic [N-1:0]     s_axis_tready;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tuser;
    logic             m_axis_tready;
    logic [N-1:0]     grant;
    logic             truncated;

    always #5 gtx_clk = ~gtx_clk;

    eth_tx_frame_arbiter #(
        .C_NUM_INPUTS    (N),
        .C_MAX_FRAME_LEN (MAXL)
    ) dut (
        .gtx_clk       (gtx_clk),
        .gtx_rst_n     (gtx_rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .grant         (grant),
        .truncated     (truncated)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Entry layout: {user, last, data}
    logic [9:0]  src_q [N][$];
    logic [9:0]  exp_q [$];
    bit          m_idle;
    int unsigned m_last;
    int unsigned m_owner;
    int unsigned pos;
    logic [N-1:0] exp_grant;
    bit          exp_trunc;
    bit          held;
    logic [9:0]  held_val;
    int unsigned trunc_seen, trunc_exp, out_cnt, cyc;
    int          first_v, first_o;
    int unsigned vld_pct, rdy_pct;

    task automatic model_reset();
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        m_idle    = 1'b1;
        m_last    = N - 1;
        m_owner   = 0;
        pos       = 0;
        exp_grant = '0;
        exp_trunc = 1'b0;
        held      = 1'b0;
    endtask

    task automatic make_frame(input int unsigned src, input int unsigned len, input bit clean_user);
        logic [9:0] e;
        for (int unsigned k = 0; k < len; k++) begin
            e[7:0] = 8'($urandom);
            e[8]   = (k == len - 1);
            e[9]   = clean_user ? 1'b0 : ($urandom_range(3) == 0);
            src_q[src].push_back(e);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            logic [9:0] e;
            e = '0;
            s_axis_tvalid[i] = 1'b0;
            if (src_q[i].size() > 0 && $urandom_range(99) < vld_pct) begin
                e = src_q[i][0];
                s_axis_tvalid[i] = 1'b1;
            end
            s_axis_tdata[8*i +: 8] = e[7:0];
            s_axis_tlast[i]        = e[8];
            s_axis_tuser[i]        = e[9];
        end
        m_axis_tready = ($urandom_range(99) < rdy_pct);
    endtask

    // One clock: sample and score at the falling edge, then drive just after the rising edge.
    task automatic step();
        logic [N-1:0] acc;
        logic [9:0]   e;
        int unsigned  w, len;
        @(negedge gtx_clk);
        check("grant", grant, exp_grant);
        check("ready_outside_grant", s_axis_tready & ~exp_grant, 0);
        check("truncated", truncated, exp_trunc);
        if (held)
            check("stall_stable", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {1'b1, held_val});
        held     = m_axis_tvalid & ~m_axis_tready;
        held_val = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        if (first_v < 0 && |s_axis_tvalid) first_v = cyc;
        if (first_o < 0 && m_axis_tvalid)  first_o = cyc;
        if (truncated) trunc_seen++;
        if (m_axis_tvalid && m_axis_tready) begin
            out_cnt++;
            if (exp_q.size() == 0) check("extra_output_byte", exp_q.size(), 1);
            else check("out_byte", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
        end
        exp_trunc = 1'b0;
        acc = s_axis_tvalid & s_axis_tready;
        if (m_idle) begin
            if (|s_axis_tvalid) begin
                w = m_last;
                for (int unsigned k = 1; k <= N; k++) begin
                    if (s_axis_tvalid[(m_last + k) % N]) begin
                        w = (m_last + k) % N;
                        break;
                    end
                end
                m_last    = w;
                m_owner   = w;
                m_idle    = 1'b0;
                exp_grant = N'(1) << w;
                len = 0;
                while (!src_q[w][len][8]) len++;
                len++;
                for (int unsigned k = 0; k < len && k < MAXL; k++) begin
                    e = src_q[w][k];
                    if (k == MAXL - 1 && len > MAXL) e[9:8] = 2'b11;
                    exp_q.push_back(e);
                end
            end
        end else if (acc[m_owner]) begin
            e = src_q[m_owner].pop_front();
            pos++;
            if (pos == MAXL && !e[8]) begin
                exp_trunc = 1'b1;
                trunc_exp++;
            end
            if (e[8]) begin
                m_idle    = 1'b1;
                exp_grant = '0;
                pos       = 0;
            end
        end
        cyc++;
        @(posedge gtx_clk);
        #1;
        drive_inputs();
    endtask

    function automatic bit busy();
        bit b;
        b = !m_idle || exp_q.size() > 0 || m_axis_tvalid;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic run_until_drained(input int unsigned limit);
        int unsigned n;
        n = 0;
        while (busy() && n < limit) begin
            step();
            n++;
        end
        check("drain_within_budget", busy(), 0);
    endtask

    initial begin
        trunc_seen = 0; trunc_exp = 0; out_cnt = 0; cyc = 0;
        first_v = -1; first_o = -1;
        vld_pct = 0; rdy_pct = 100;
        gtx_rst_n     = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b0;
        model_reset();

        repeat (2) @(posedge gtx_clk);
        @(negedge gtx_clk);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_m_tlast_tuser", {m_axis_tlast, m_axis_tuser}, 0);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_grant", grant, 0);
        check("rst_truncated", truncated, 0);
        gtx_rst_n = 1'b1;
        repeat (3) step();

        // Single frame, always ready: latency and exact pass-through
        make_frame(0, 30, 1'b0);
        vld_pct = 100; rdy_pct = 100;
        first_v = -1; first_o = -1;
        drive_inputs();
        run_until_drained(200);
        check("first_byte_latency", 32'(first_o - first_v), 2);

        // Mixed random traffic including exact-length and over-length frames
        make_frame(1, MAXL, 1'b1);
        make_frame(2, MAXL + 4, 1'b0);
        make_frame(0, MAXL - 1, 1'b0);
        for (int s = 0; s < N; s++)
            for (int f = 0; f < 10; f++)
                make_frame(s, $urandom_range(1, 50), 1'b0);
        make_frame(1, MAXL + 7, 1'b0);
        make_frame(1, 3, 1'b0);
        vld_pct = 70; rdy_pct = 60;
        drive_inputs();
        run_until_drained(20000);
        check("truncated_pulse_count", trunc_seen, trunc_exp);

        // Reset in the middle of a frame
        make_frame(1, 30, 1'b0);
        vld_pct = 100; rdy_pct = 100;
        drive_inputs();
        out_cnt = 0;
        for (int k = 0; k < 40 && out_cnt < 5; k++) step();
        #2;
        gtx_rst_n = 1'b0;
        #1;
        check("midrst_m_tvalid", m_axis_tvalid, 0);
        check("midrst_m_tdata", m_axis_tdata, 0);
        check("midrst_grant", grant, 0);
        check("midrst_s_tready", s_axis_tready, 0);
        model_reset();
        drive_inputs();
        @(negedge gtx_clk);
        gtx_rst_n = 1'b1;
        repeat (3) step();
        make_frame(0, 4, 1'b0);
        make_frame(1, 4, 1'b0);
        drive_inputs();
        step();
        check("first_grant_after_reset", grant, 1);
        run_until_drained(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_frame_arbiter.md
# eth_tx_frame_arbiter

Frame-granular round-robin arbiter that shares one 1G MAC transmit AXI-Stream port (8-bit, `gtx_clk` domain) between several frame sources. It sits directly in front of the MAC wrapper's `tx_axis_*` input. It never interleaves bytes of different frames, and it truncates runaway frames so that a faulty source cannot hold the link.

## Interface

Parameters:
- `C_NUM_INPUTS`, default 2: number of requesters, legal range 2..8.
- `C_MAX_FRAME_LEN`, default 1522: maximum bytes forwarded per frame (legal 2..16383); longer frames are truncated.

Ports:
- `gtx_clk`  in  1: single clock for the whole block.
- `gtx_rst_n`  in  1: asynchronous, active-low reset.
- `s_axis_tdata`  in  8*C_NUM_INPUTS: input i occupies bits [8i+7:8i].
- `s_axis_tvalid`  in  C_NUM_INPUTS: per-input valid.
- `s_axis_tlast`  in  C_NUM_INPUTS: per-input end of frame.
- `s_axis_tuser`  in  C_NUM_INPUTS: per-input frame error flag (meaningful on tlast).
- `s_axis_tready`  out  C_NUM_INPUTS: per-input ready.
- `m_axis_tdata`  out  8: to MAC `tx_axis_tdata`.
- `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser`  out  1 each: to the MAC.
- `m_axis_tready`  in  1: from the MAC.
- `grant`  out  C_NUM_INPUTS: one-hot owner of the current frame; all zero when idle.
- `truncated`  out  1: one-cycle pulse when a frame is cut.

## Operation

- State machine, 3 states:
  - IDLE → PASS when any `s_axis_tvalid` is high. The winner is the first valid index searched from `last+1` modulo N. `grant` and `last` are registered on that edge.
  - PASS → IDLE on an accepted input byte with tlast=1.
  - PASS → DROP on acceptance of byte number `C_MAX_FRAME_LEN` when its tlast=0.
  - DROP → IDLE on an accepted input byte with tlast=1.
- In PASS, the granted input's ready equals the internal stage-ready. All other readies are 0.
- In DROP, the granted input's ready is 1. Its bytes are discarded and nothing reaches `m_axis`.
- In IDLE, all readies are 0.
- Byte counter:
  - width `$clog2(C_MAX_FRAME_LEN+1)`;
  - cleared on entry to PASS;
  - incremented per accepted byte;
  - never wraps.
- Truncation:
  - The `C_MAX_FRAME_LEN`-th byte is forwarded with tlast=1 and tuser=1.
  - `truncated` pulses in the cycle after that byte is accepted.
  - If that byte already carries tlast=1, the frame is forwarded normally: its own tuser is kept and there is no pulse.
- Output stage:
  - single register holding tdata/tlast/tuser/tvalid;
  - stage-ready = `~m_axis_tvalid | m_axis_tready`;
  - tuser and tlast pass through unmodified except when truncating.
- Input tvalid dropping mid-frame is legal and stalls the frame. Grant is held until tlast.

## Timing

- Reset (async assert) values:
  - all `m_axis_*` 0;
  - `s_axis_tready` 0;
  - `grant` 0;
  - `truncated` 0;
  - state IDLE;
  - `last` = N-1, so input 0 wins first;
  - counter 0.
- Deassertion is taken synchronously by the internal logic (no glitch on the first edge).
- Latency, with the input valid at cycle c and the MAC always ready:
  - grant at c+1;
  - first ready/accept at c+1;
  - first byte on `m_axis` at c+2.
- Throughput is 1 byte/cycle while `m_axis_tready`=1; there are no bubbles inside a frame.
- Gap between frames is 1 idle arbitration cycle on the input side. The output may stay continuous if it is stalled.
- Output is AXI-Stream compliant: once asserted, `m_axis_tvalid` and its data stay stable until `m_axis_tready`.
- Simultaneous requests are resolved by the round-robin rule only. A requester that drops valid before the grant loses nothing.
- Reset mid-frame: everything is cleared immediately. A partial frame in flight is lost; the MAC shares `gtx_rst_n`.

## Structure

- Package `eth_tx_arb_pkg` holds:
  - the state enum (IDLE, PASS, DROP);
  - the counter width function;
  - the `C_NUM_INPUTS` range check.
- Sub-module `rr_pick`: combinational round-robin one-hot selector. Inputs are request vector and last index; output is one-hot grant plus encoded index.
- The top holds the FSM, byte counter, mux and output register.

## Test plan

- Single frame: input 0 sends 64 bytes 0x00..0x3F, MAC ready=1 → identical 64 bytes out, tlast only on 0x3F, first byte 2 cycles after tvalid, `grant`=01 throughout.
- Contention: N=2, both inputs continuously offer 10-byte frames (x3 each) → output frame order 0,1,0,1,0,1, no interleaving, `grant` toggles only after tlast.
- Backpressure: `m_axis_tready` pattern 1,0,1,0… during a 32-byte frame → all 32 bytes out exactly once in order, tdata stable while stalled.
- Truncation: `C_MAX_FRAME_LEN`=16, input 1 sends 20 bytes → 16 bytes out, byte 16 has tlast=1/tuser=1, one `truncated` pulse, remaining 4 bytes consumed with ready=1, next frame forwarded normally.
- Exact length: 16-byte frame with `C_MAX_FRAME_LEN`=16 and tuser=0 → normal tlast, tuser=0, no pulse.
- Reset mid-frame: assert `gtx_rst_n`=0 after 5 bytes → all outputs 0 without waiting for a clock edge. After release, inputs 0 and 1 both valid → input 0 granted first.
